// File: rtl/ref_window_loader.sv
// ref_window_loader
// Assembles a WIN x WIN reference-pixel window from a narrow stream of
// BEAT_PIX-pixel beats, in row-major order. The finished window is held
// stable until the downstream interpolator signals consume.
//
// Handshake: a beat transfers on a rising edge where in_valid and in_ready
// are both high. in_ready is decoded from the registered state only, so
// there is no combinational path from in_valid to in_ready. in_data is
// ignored whenever in_ready is low.
module ref_window_loader #(
    parameter int WIN      = 15,
    parameter int PIX_W    = 8,
    parameter int BEAT_PIX = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [BEAT_PIX*PIX_W-1:0]  in_data,
    input  logic                       consume,
    output logic [WIN*WIN*PIX_W-1:0]   window_out,
    output logic                       window_valid,
    output logic                       busy,
    output logic [1:0]                 dbg_state
);

    localparam int BEATS  = WIN / BEAT_PIX;
    localparam int LANE_W = BEAT_PIX * PIX_W;
    localparam int ROW_W  = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int BC_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int IDX_W  = $clog2(WIN * WIN * PIX_W);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FULL = 2'd2
    } state_e;

    state_e                     state_q, state_d;
    logic [ROW_W-1:0]           row_cnt_q, row_cnt_d;
    logic [BC_W-1:0]            beat_cnt_q, beat_cnt_d;
    logic [WIN*WIN*PIX_W-1:0]   window_q;
    logic                       accept;
    logic                       last_beat;
    logic                       last_row;
    logic [IDX_W-1:0]           wr_bit;

    // Outputs depend only on the registered state.
    assign in_ready     = (state_q == ST_LOAD);
    assign busy         = (state_q == ST_LOAD);
    assign window_valid = (state_q == ST_FULL);
    assign window_out   = window_q;
    assign dbg_state    = state_q;

    assign accept    = in_valid & in_ready;
    assign last_beat = (beat_cnt_q == BC_W'(BEATS - 1));
    assign last_row  = (row_cnt_q == ROW_W'(WIN - 1));

    // Bit offset of the first pixel of the current beat in the window.
    always_comb begin
        wr_bit = IDX_W'((int'(row_cnt_q) * WIN + int'(beat_cnt_q) * BEAT_PIX) * PIX_W);
    end

    // Next-state and counter logic.
    always_comb begin
        state_d    = state_q;
        row_cnt_d  = row_cnt_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_LOAD;
                    row_cnt_d  = '0;
                    beat_cnt_d = '0;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    if (last_beat) begin
                        beat_cnt_d = '0;
                        if (last_row) begin
                            row_cnt_d = '0;
                            state_d   = ST_FULL;
                        end else begin
                            row_cnt_d = row_cnt_q + ROW_W'(1);
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + BC_W'(1);
                    end
                end
            end
            ST_FULL: begin
                if (consume) begin
                    if (start) begin
                        state_d    = ST_LOAD;
                        row_cnt_d  = '0;
                        beat_cnt_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                row_cnt_d  = '0;
                beat_cnt_d = '0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            row_cnt_q  <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            row_cnt_q  <= row_cnt_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Window storage: only the addressed beat lane changes on an accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            window_q <= '0;
        end else if (accept) begin
            window_q[wr_bit +: LANE_W] <= in_data;
        end
    end

endmodule

// File: tb/tb_ref_window_loader.sv
// Testbench for ref_window_loader: directed scenarios plus randomized loads,
// checked against a linear-index model of the window.
module tb_ref_window_loader;

    localparam int WIN   = 15;
    localparam int NPIX  = WIN * WIN;
    localparam int NBEAT = NPIX / 5;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           in_valid;
    logic           in_ready;
    logic [39:0]    in_data;
    logic           consume;
    logic [1799:0]  window_out;
    logic           window_valid;
    logic           busy;
    logic [1:0]     dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: state 0=IDLE 1=LOAD 2=FULL, pixels by linear index.
    logic [7:0] m_win [NPIX];
    int         m_st;
    int         m_beats;

    ref_window_loader dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .consume      (consume),
        .window_out   (window_out),
        .window_valid (window_valid),
        .busy         (busy),
        .dbg_state    (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] dut_pix(input int i);
        return window_out[i*8 +: 8];
    endfunction

    function automatic logic [39:0] beat_pat(input int k);
        logic [39:0] d;
        for (int j = 0; j < 5; j++) d[j*8 +: 8] = 8'((k * 5 + j) % 256);
        return d;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NPIX; i++) m_win[i] = 8'h00;
        m_st    = 0;
        m_beats = 0;
    endtask

    // Applies the behaviour of one clock edge to the model.
    task automatic model_edge();
        case (m_st)
            0: if (start) begin m_st = 1; m_beats = 0; end
            1: if (in_valid) begin
                for (int j = 0; j < 5; j++) m_win[m_beats*5 + j] = in_data[j*8 +: 8];
                m_beats++;
                if (m_beats == NBEAT) begin m_st = 2; m_beats = 0; end
            end
            2: if (consume) m_st = start ? 1 : 0;
            default: m_st = 0;
        endcase
    endtask

    task automatic check_outputs();
        check("in_ready", in_ready, m_st == 1);
        check("busy", busy, m_st == 1);
        check("window_valid", window_valid, m_st == 2);
        check("state", dbg_state, m_st);
    endtask

    task automatic check_window(input string tag);
        for (int i = 0; i < NPIX; i++) check(tag, dut_pix(i), m_win[i]);
    endtask

    // Driver: one clock edge, model update, then sample 1 ns later.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset();
        #2 rst = 1'b1;
        model_reset();
        #1;
        check_outputs();
        check_window("reset_window");
        #2 rst = 1'b0;
    endtask

    initial begin
        int k;
        int cyc;
        logic [63:0] rnd;

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; consume = 1'b0;
        model_reset();
        #1;
        check_outputs();
        check_window("init_reset_window");
        #6 rst = 1'b0;

        // Basic fill: start pulse then 45 back-to-back beats
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        for (int b = 0; b < NBEAT; b++) begin
            in_data = beat_pat(b);
            tick();
        end
        in_valid = 1'b0;
        check("fill_valid_after_46", window_valid, 1'b1);
        check_window("fill_window");
        for (int r = 0; r < WIN; r++)
            for (int c = 0; c < WIN; c++)
                check("fill_pattern", dut_pix(r*WIN + c), (r*WIN + c) % 256);
        check("pix_14_14", dut_pix(224), 224);

        // Hold: FULL ignores beats and a lone start
        in_valid = 1'b1;
        in_data  = 40'hFF_FFFF_FFFF;
        for (int i = 0; i < 10; i++) begin
            start = (i == 4);
            tick();
        end
        start = 1'b0;
        in_valid = 1'b0;
        check_window("hold_window");

        // Release
        consume = 1'b1;
        tick();
        consume = 1'b0;
        check("release_valid", window_valid, 1'b0);

        // Stalls: in_valid toggles, junk data on idle cycles
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        cyc = 0;
        while (m_st == 1 && cyc < 200) begin
            in_valid = (cyc % 2 == 0);
            rnd = {$urandom, $urandom};
            in_data = in_valid ? beat_pat(k) : rnd[39:0];
            tick();
            if (in_valid) k++;
            cyc++;
        end
        in_valid = 1'b0;
        check("stall_cycles", cyc, 89);
        check("stall_beats", k, NBEAT);
        check("stall_valid", window_valid, 1'b1);
        for (int i = 0; i < NPIX; i++) check("stall_pattern", dut_pix(i), i % 256);

        // Back-to-back: consume and start together
        consume = 1'b1;
        start = 1'b1;
        tick();
        consume = 1'b0;
        start = 1'b0;
        check("b2b_ready", in_ready, 1'b1);
        in_valid = 1'b1;
        in_data = {5{8'h5A}};
        for (int b = 0; b < NBEAT; b++) tick();
        in_valid = 1'b0;
        check("b2b_valid", window_valid, 1'b1);
        for (int i = 0; i < NPIX; i++) check("b2b_pattern", dut_pix(i), 8'h5A);

        // Randomized loads with random valid, start and consume noise
        for (int t = 0; t < 3; t++) begin
            consume = 1'b1;
            start = 1'b1;
            tick();
            consume = 1'b0;
            start = 1'b0;
            cyc = 0;
            while (m_st == 1 && cyc < 400) begin
                in_valid = 1'($urandom_range(0, 1));
                start = 1'($urandom_range(0, 1));
                consume = 1'($urandom_range(0, 1));
                rnd = {$urandom, $urandom};
                in_data = rnd[39:0];
                tick();
                cyc++;
            end
            in_valid = 1'b0;
            start = 1'b0;
            consume = 1'b0;
            check("rand_done", window_valid, 1'b1);
            check_window("rand_window");
        end

        // Reset mid-load after 20 beats
        consume = 1'b1;
        start = 1'b1;
        tick();
        consume = 1'b0;
        start = 1'b0;
        in_valid = 1'b1;
        for (int b = 0; b < 20; b++) begin
            rnd = {$urandom, $urandom};
            in_data = rnd[39:0];
            tick();
        end
        in_valid = 1'b0;
        do_reset();
        // No start: beats must be ignored
        in_valid = 1'b1;
        in_data = 40'h12_3456_789A;
        for (int i = 0; i < 4; i++) tick();
        in_valid = 1'b0;
        check_window("post_reset_idle_window");

        // Full reload after reset needs exactly 45 beats
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        cyc = 0;
        while (m_st == 1 && cyc < 100) begin
            in_data = beat_pat(cyc);
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        check("reload_beats", cyc, NBEAT);
        check("reload_valid", window_valid, 1'b1);
        for (int i = 0; i < NPIX; i++) check("reload_pattern", dut_pix(i), i % 256);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
